// File: rtl/ecc_serial_loader_if.sv
// Handshake and serial-operand bundle between the pin-level wrapper and the ECC loader.
// Optional o_proto_err member present when ECC_LOADER_PROTO_ERR_EN is defined.
interface ecc_serial_loader_if #(
  parameter int unsigned MAX_BITS = 128
);
  logic                i_data_valid;
  logic                i_mode;
  logic                i_a;
  logic                i_prime;
  logic                i_Px;
  logic                i_Py;
  logic                i_m;
  logic                i_load_ready;
  logic                o_load_valid;
  logic                o_load_kind;
  logic [1:0]          o_mode;
  logic [MAX_BITS-1:0] o_a;
  logic [MAX_BITS-1:0] o_prime;
  logic [MAX_BITS-1:0] o_Px;
  logic [MAX_BITS-1:0] o_Py;
  logic [MAX_BITS-1:0] o_m;
  logic                o_busy;
`ifdef ECC_LOADER_PROTO_ERR_EN
  logic                o_proto_err;
`endif

  // Loader side: consumes the serial stream, produces operands.
  modport slave (
    input  i_data_valid, i_mode, i_a, i_prime, i_Px, i_Py, i_m, i_load_ready,
`ifdef ECC_LOADER_PROTO_ERR_EN
    output o_proto_err,
`endif
    output o_load_valid, o_load_kind, o_mode, o_a, o_prime, o_Px, o_Py, o_m, o_busy
  );

  // Wrapper / bench side.
  modport master (
    output i_data_valid, i_mode, i_a, i_prime, i_Px, i_Py, i_m, i_load_ready,
`ifdef ECC_LOADER_PROTO_ERR_EN
    input  o_proto_err,
`endif
    input  o_load_valid, o_load_kind, o_mode, o_a, o_prime, o_Px, o_Py, o_m, o_busy
  );
endinterface

// File: rtl/ecc_serial_loader.sv
// Bit-serial MSB-first operand deserializer feeding the ECC point-multiplication core.
// Full frames carry mode + a, prime, Px, Py, m; point-only frames reload Px/Py only.
// Optional macro ECC_LOADER_PROTO_ERR_EN adds a sticky stray-strobe flag and a transfer counter.
module ecc_serial_loader #(
  parameter int unsigned MAX_BITS = 128,
  parameter int unsigned CNT_W    = 7
) (
  input logic                   clk,
  input logic                   rst,
  ecc_serial_loader_if.slave    bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StModeHi = 3'd1;
  localparam logic [2:0] StModeLo = 3'd2;
  localparam logic [2:0] StShift  = 3'd3;
  localparam logic [2:0] StHold   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                kind_q, kind_d;
  logic                full_seen_q, full_seen_d;
  logic [MAX_BITS-1:0] a_q, a_d, p_q, p_d, px_q, px_d, py_q, py_d, m_q, m_d;
  logic                xfer;

  // Index of the last bit for a width mode; widths beyond MAX_BITS saturate.
  function automatic logic [CNT_W-1:0] last_bit(input logic [1:0] mode);
    int unsigned n;
    case (mode)
      2'b00:   n = 16;
      2'b01:   n = 32;
      2'b10:   n = 64;
      default: n = 128;
    endcase
    if (n > MAX_BITS) n = MAX_BITS;
    return CNT_W'(n - 1);
  endfunction

  assign xfer = (state_q == StHold) && bus.i_load_ready;

  // Frame sequencing and operand assembly.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    kind_d      = kind_q;
    full_seen_d = full_seen_q;
    a_d         = a_q;
    p_d         = p_q;
    px_d        = px_q;
    py_d        = py_q;
    m_d         = m_q;
    case (state_q)
      StIdle: begin
        if (bus.i_data_valid) begin
          if (!full_seen_q) begin
            state_d = StModeHi;
          end else begin
            // Point-only frame reuses the stored mode and curve parameters.
            px_d    = '0;
            py_d    = '0;
            cnt_d   = last_bit(mode_q);
            kind_d  = 1'b1;
            state_d = StShift;
          end
        end
      end
      StModeHi: begin
        mode_d[1] = bus.i_mode;
        state_d   = StModeLo;
      end
      StModeLo: begin
        mode_d[0] = bus.i_mode;
        // Clearing here provides the zero-extension above N bits.
        a_d       = '0;
        p_d       = '0;
        px_d      = '0;
        py_d      = '0;
        m_d       = '0;
        cnt_d     = last_bit({mode_q[1], bus.i_mode});
        kind_d    = 1'b0;
        state_d   = StShift;
      end
      StShift: begin
        px_d = {px_q[MAX_BITS-2:0], bus.i_Px};
        py_d = {py_q[MAX_BITS-2:0], bus.i_Py};
        if (!kind_q) begin
          a_d = {a_q[MAX_BITS-2:0], bus.i_a};
          p_d = {p_q[MAX_BITS-2:0], bus.i_prime};
          m_d = {m_q[MAX_BITS-2:0], bus.i_m};
        end
        if (cnt_q == '0) state_d = StHold;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StHold: begin
        if (bus.i_load_ready) begin
          state_d = StIdle;
          if (!kind_q) full_seen_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      cnt_q       <= '0;
      kind_q      <= 1'b0;
      full_seen_q <= 1'b0;
      a_q         <= '0;
      p_q         <= '0;
      px_q        <= '0;
      py_q        <= '0;
      m_q         <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      kind_q      <= kind_d;
      full_seen_q <= full_seen_d;
      a_q         <= a_d;
      p_q         <= p_d;
      px_q        <= px_d;
      py_q        <= py_d;
      m_q         <= m_d;
    end
  end

  assign bus.o_load_valid = (state_q == StHold);
  assign bus.o_load_kind  = kind_q;
  assign bus.o_mode       = mode_q;
  assign bus.o_a          = a_q;
  assign bus.o_prime      = p_q;
  assign bus.o_Px         = px_q;
  assign bus.o_Py         = py_q;
  assign bus.o_m          = m_q;
  assign bus.o_busy       = (state_q != StIdle);

`ifdef ECC_LOADER_PROTO_ERR_EN
  logic        proto_err_q;
  logic [31:0] frame_cnt_q;

  // Sticky stray-strobe flag and accepted-transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (bus.i_data_valid && (state_q != StIdle)) proto_err_q <= 1'b1;
      if (xfer) frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end

  assign bus.o_proto_err = proto_err_q;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: doc/ecc_serial_loader.md
Name: ecc_serial_loader

Overview:
- Input deserializer directly upstream of the ECC point-multiplication core inside the top-level serial wrapper.
- Receives the bit-serial, MSB-first operand stream on the wrapper's pins and decodes the 2-bit width mode.
- Assembles zero-extended MAX_BITS-wide operands and hands them to the core through a valid/ready handshake.
- Supports two frame types: full frame (mode + a, prime, Px, Py, m) and point-only frame (new Px, Py reusing the stored parameters).

Parameters:
MAX_BITS, 128, width of the parallel operand registers
CNT_W, 7, bit-counter width, ceil(log2(MAX_BITS))

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
i_data_valid  input  1  one-cycle frame-start strobe
i_mode  input  1  serial mode bits, MSB first (full frame only)
i_a  input  1  serial curve coefficient a
i_prime  input  1  serial modulus p
i_Px  input  1  serial point x
i_Py  input  1  serial point y
i_m  input  1  serial scalar m
i_load_ready  input  1  core can accept operands
o_load_valid  output  1  operands complete and stable
o_load_kind  output  1  0 = full frame, 1 = point-only frame
o_mode  output  2  00=16, 01=32, 10=64, 11=128 bits
o_a, o_prime, o_Px, o_Py, o_m  output  MAX_BITS each  parallel operands, zero-extended
o_busy  output  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - All operand registers and o_mode are cleared to 0.
  - o_load_valid=0, o_load_kind=0, o_busy=0.
  - full_seen flag is cleared. Applies mid-frame as well; the partial frame is discarded.
- Width N by o_mode: 16/32/64/128. Mode 11 with MAX_BITS<128 saturates to MAX_BITS.
- FSM states: IDLE, MODE_HI, MODE_LO, SHIFT, HOLD.
- IDLE, on i_data_valid=1:
  - If full_seen=0: go to MODE_HI.
  - If full_seen=1: point-only frame. Clear o_Px and o_Py, load counter with N-1, set kind=1, go to SHIFT.
- MODE_HI: sample o_mode[1]=i_mode, then go to MODE_LO.
- MODE_LO:
  - Sample o_mode[0]=i_mode.
  - Clear all five operand registers.
  - Load counter with N-1 (N from the new mode), set kind=0, go to SHIFT.
- SHIFT, every cycle:
  - Each active register shifts: reg <= {reg[MAX_BITS-2:0], serial_bit}.
  - Full frame: all five registers shift. Point-only frame: only Px and Py shift; a, prime and m hold.
  - When counter=0 (the Nth bit is sampled), go to HOLD. Otherwise decrement the counter.
  - Bits above N remain 0 (zero-extension comes from the clear).
- HOLD:
  - o_load_valid=1; operands and o_load_kind are stable.
  - Transfer happens in the cycle where o_load_valid && i_load_ready.
  - Next state is IDLE with o_load_valid=0. full_seen is set when kind=0.
- i_data_valid while in MODE_HI, MODE_LO, SHIFT or HOLD: ignored. It neither restarts nor corrupts the frame.
- Timing, full frame (strobe at cycle 0): mode bits at cycles 1–2, data bits at cycles 3..N+2, o_load_valid first high at cycle N+3.
- Timing, point-only frame: data bits at cycles 1..N, o_load_valid first high at cycle N+1.
- i_load_ready already high on entry to HOLD: o_load_valid is high for exactly one cycle.
- Serial inputs are don't-care outside their sampling cycles; X there must not propagate.

Optional Feature:
- Macro: ECC_LOADER_PROTO_ERR_EN.
- Defined:
  - Adds output o_proto_err (1 bit), a sticky flag set when i_data_valid=1 in any non-IDLE state.
  - Cleared only by rst.
  - Also adds a 32-bit frame counter, readable through hierarchy for benches, counting accepted transfers.
- Undefined: no port and no logic; stray strobes are silently ignored.

Test Plan:
- Full frame, 16-bit. After rst, strobe, mode bits 0,0, then a=16'h0002, p=16'hFFF1, Px=16'h1234, Py=16'hABCD, m=16'h00FF MSB first, ready=1. Required: o_load_valid high at cycle 19 for one cycle, o_mode=00, kind=0, o_Px=128'h1234, upper 112 bits 0.
- Point-only frame after the above. Strobe, Px=16'h5555, Py=16'hAAAA. Required: o_load_valid at cycle 17, kind=1, o_Px=128'h5555, o_Py=128'hAAAA, o_a=2, o_prime=16'hFFF1, o_m=16'h00FF unchanged.
- Backpressure. 128-bit full frame with ready=0 for 10 cycles after o_load_valid rises. Required: valid and operands held all 10 cycles; a single transfer when ready=1; returns to IDLE next cycle.
- Reset mid-SHIFT. Assert rst at bit 20 of a 64-bit frame. Required: all outputs 0 next cycle. The next strobe is treated as a full frame (mode bits expected).
- Stray strobe. i_data_valid=1 during SHIFT of a 32-bit frame. Required: the frame completes with correct values. With ECC_LOADER_PROTO_ERR_EN, o_proto_err=1 and it stays 1 until rst.
- Width switch. Full 32-bit frame, then rst, then full 64-bit frame with Px=64'h8000_0000_0000_0001. Required: o_mode=10, o_Px exact, no residue from the 32-bit frame.
